// File: rtl/psum_requant.sv
// Per-pixel channel accumulator with bias, rounding right shift and 8-bit clamp.
// Optional macro PSUM_RELU_EN: unsigned 0..255 (ReLU) clamp instead of signed saturation.
module psum_requant #(
   parameter int ACC_W  = 20,
   parameter int PSUM_W = 32,
   parameter int CH_W   = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clr,
   input  logic [CH_W-1:0]         cfg_nch,
   input  logic signed [15:0]      cfg_bias,
   input  logic [4:0]              cfg_shift,
   input  logic                    vld_i,
   input  logic signed [ACC_W-1:0] acc_i,
   output logic                    busy_o,
   output logic                    vld_o,
   output logic [7:0]              data_o
);

`ifdef PSUM_RELU_EN
   localparam logic signed [PSUM_W:0] CLAMP_HI = (PSUM_W+1)'(255);
   localparam logic signed [PSUM_W:0] CLAMP_LO = (PSUM_W+1)'(0);
`else
   localparam logic signed [PSUM_W:0] CLAMP_HI = (PSUM_W+1)'(127);
   localparam logic signed [PSUM_W:0] CLAMP_LO = (PSUM_W+1)'(-128);
`endif

   // group state and configuration latched at group start
   logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
   logic [CH_W-1:0]          nch_q, nch_d;
   logic signed [15:0]       bias_q, bias_d;
   logic [4:0]               shift_q, shift_d;
   logic signed [PSUM_W-1:0] psum_q, psum_d;

   // pipeline: S1 biased sum, S2 rounded shift, S3 clamped output
   logic signed [PSUM_W-1:0] s1_q, s1_d;
   logic [4:0]               s1_shift_q, s1_shift_d;
   logic                     s1_vld_q, s1_vld_d;
   logic signed [PSUM_W:0]   s2_q, s2_d;
   logic                     s2_vld_q, s2_vld_d;
   logic [7:0]               data_q, data_d;
   logic                     vld_q, vld_d;

   logic                     first;
   logic                     last;
   logic [CH_W-1:0]          nch_in;
   logic [CH_W-1:0]          grp_nch;
   logic signed [15:0]       grp_bias;
   logic [4:0]               grp_shift;
   logic signed [PSUM_W-1:0] acc_ext;
   logic signed [PSUM_W-1:0] bias_ext;
   logic signed [PSUM_W-1:0] sum;
   logic signed [PSUM_W:0]   s1_ext;
   logic signed [PSUM_W:0]   rnd;

   // On the first beat the live cfg inputs apply; afterwards the latched copies do.
   assign first     = (ch_cnt_q == '0);
   assign nch_in    = (cfg_nch == '0) ? CH_W'(1) : cfg_nch;
   assign grp_nch   = first ? nch_in    : nch_q;
   assign grp_bias  = first ? cfg_bias  : bias_q;
   assign grp_shift = first ? cfg_shift : shift_q;
   assign last      = (ch_cnt_q == grp_nch - CH_W'(1));
   assign acc_ext   = {{(PSUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
   assign bias_ext  = {{(PSUM_W-16){grp_bias[15]}}, grp_bias};
   assign sum       = (first ? '0 : psum_q) + acc_ext;

   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path can infer a latch.
      ch_cnt_d   = ch_cnt_q;
      nch_d      = nch_q;
      bias_d     = bias_q;
      shift_d    = shift_q;
      psum_d     = psum_q;
      s1_d       = s1_q;
      s1_shift_d = s1_shift_q;
      s1_vld_d   = 1'b0;
      if (clr) begin
         ch_cnt_d = '0;
         psum_d   = '0;
      end else if (vld_i) begin
         if (first) begin
            nch_d   = nch_in;
            bias_d  = cfg_bias;
            shift_d = cfg_shift;
         end
         psum_d = sum;
         if (last) begin
            s1_d       = sum + bias_ext;
            s1_shift_d = grp_shift;
            s1_vld_d   = 1'b1;
            ch_cnt_d   = '0;
         end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
         end
      end
   end

   // Rounding add is one bit wider so a near-max sum cannot wrap before the shift.
   assign s1_ext = {s1_q[PSUM_W-1], s1_q};
   assign rnd    = (PSUM_W+1)'(1) << (s1_shift_q - 5'd1);

   always_comb begin
      s2_vld_d = s1_vld_q & ~clr;
      s2_d     = (s1_shift_q == 5'd0) ? s1_ext : ((s1_ext + rnd) >>> s1_shift_q);
      vld_d    = s2_vld_q & ~clr;
      data_d   = data_q;
      if (s2_vld_q && !clr) begin
         if (s2_q > CLAMP_HI)      data_d = CLAMP_HI[7:0];
         else if (s2_q < CLAMP_LO) data_d = CLAMP_LO[7:0];
         else                      data_d = s2_q[7:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rstn) begin
         ch_cnt_q   <= '0;
         nch_q      <= '0;
         bias_q     <= '0;
         shift_q    <= '0;
         psum_q     <= '0;
         s1_q       <= '0;
         s1_shift_q <= '0;
         s1_vld_q   <= 1'b0;
         s2_q       <= '0;
         s2_vld_q   <= 1'b0;
         data_q     <= '0;
         vld_q      <= 1'b0;
      end else begin
         ch_cnt_q   <= ch_cnt_d;
         nch_q      <= nch_d;
         bias_q     <= bias_d;
         shift_q    <= shift_d;
         psum_q     <= psum_d;
         s1_q       <= s1_d;
         s1_shift_q <= s1_shift_d;
         s1_vld_q   <= s1_vld_d;
         s2_q       <= s2_d;
         s2_vld_q   <= s2_vld_d;
         data_q     <= data_d;
         vld_q      <= vld_d;
      end
   end

   assign busy_o = (ch_cnt_q != '0);
   assign vld_o  = vld_q;
   assign data_o = data_q;

endmodule
